// File: rtl/pingpong_ram_if.sv
// Streaming port bundle for the ping-pong frame RAM.
// The producer/consumer side takes the master modport; the RAM takes the slave modport.
interface pingpong_ram_if #(
    parameter int NB = 16
);
    logic          ED;
    logic          START;
    logic [NB-1:0] DI;
    logic          HOLD;
    logic [NB-1:0] DO;
    logic          DVALID;
    logic          RDY;
    logic          OVF;

    modport master (
        output ED, START, DI, HOLD,
        input  DO, DVALID, RDY, OVF
    );

    modport slave (
        input  ED, START, DI, HOLD,
        output DO, DVALID, RDY, OVF
    );
endinterface

// File: rtl/pingpong_ram.sv
// Double-buffered frame RAM: one bank fills with a 2^LOGN-sample frame while the other streams out.
// Define BITREV_EN to read each frame in bit-reversed address order (FFT output reordering).
module pingpong_ram #(
    parameter int NB   = 16,
    parameter int LOGN = 6
) (
    input logic           CLK,
    input logic           RST,
    pingpong_ram_if.slave bus
);
    localparam int DEPTH = 1 << LOGN;
    localparam logic [LOGN-1:0] LAST = '1;

    // Both banks share one array; the top address bit selects the bank.
    logic [NB-1:0]   mem [0:2*DEPTH-1];

    logic            wbank;
    logic            wactive;
    logic            ractive;
    logic            ovf;
    logic            dvalid;
    logic            rdy;
    logic [LOGN-1:0] wcnt;
    logic [LOGN-1:0] rcnt;
    logic [LOGN-1:0] waddr;
    logic [LOGN-1:0] raddr;
    logic [NB-1:0]   dout;
    logic            we;
    logic            wlast;
    logic            rd_issue;
    logic            rlast;

    always_comb begin
        we       = bus.START || wactive;
        waddr    = bus.START ? '0 : wcnt;
        wlast    = we && (waddr == LAST);
        rd_issue = ractive && !bus.HOLD;
        rlast    = rd_issue && (rcnt == LAST);
    end

`ifdef BITREV_EN
    always_comb begin
        raddr = '0;
        for (int i = 0; i < LOGN; i++) begin
            raddr[i] = rcnt[LOGN-1-i];
        end
    end
`else
    assign raddr = rcnt;
`endif

    always_ff @(posedge CLK) begin
        if (!RST && bus.ED && we) begin
            mem[{wbank, waddr}] <= bus.DI;
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            wbank   <= 1'b0;
            wcnt    <= '0;
            wactive <= 1'b0;
            rcnt    <= '0;
            ractive <= 1'b0;
            ovf     <= 1'b0;
            dout    <= '0;
            dvalid  <= 1'b0;
            rdy     <= 1'b0;
        end else if (bus.ED) begin
            if (bus.START) begin
                wcnt    <= LOGN'(1);
                wactive <= 1'b1;
            end else if (wactive) begin
                wcnt <= wcnt + LOGN'(1);
            end

            if (rd_issue) begin
                dout   <= mem[{~wbank, raddr}];
                dvalid <= 1'b1;
                rdy    <= (rcnt == '0);
                rcnt   <= rcnt + LOGN'(1);
                if (rlast) begin
                    ractive <= 1'b0;
                end
            end else begin
                dvalid <= 1'b0;
                rdy    <= 1'b0;
            end

            // Completion hands the fresh bank to the reader and drops any unread tail.
            if (wlast) begin
                wactive <= 1'b0;
                wbank   <= ~wbank;
                ractive <= 1'b1;
                rcnt    <= '0;
                if (ractive && !rlast) begin
                    ovf <= 1'b1;
                end
            end
        end
    end

    assign bus.DO     = dout;
    assign bus.DVALID = dvalid;
    assign bus.RDY    = rdy;
    assign bus.OVF    = ovf;
endmodule

// File: tb/tb_pingpong_ram.sv
// Directed self-checking bench for pingpong_ram (NB=16, LOGN=6).
// Expected read order follows BITREV_EN when the macro is defined for the build.
module tb_pingpong_ram;
    localparam int NB   = 16;
    localparam int LOGN = 6;

    typedef struct {
        logic        start;
        logic [15:0] di;
        logic [15:0] exp_do;
        logic        exp_dv;
        logic        exp_rdy;
    } vec_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   errors = 0;
    int   checks = 0;
    vec_t vecs [130];

    pingpong_ram_if #(.NB(NB)) bus ();

    pingpong_ram #(.NB(NB), .LOGN(LOGN)) dut (
        .CLK (clk),
        .RST (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    // Sample value expected at read position k of a frame written with data == address.
    function automatic logic [15:0] ord(input int k);
        logic [5:0] a;
        logic [5:0] r;
        a = 6'(k);
        r = a;
`ifdef BITREV_EN
        for (int i = 0; i < 6; i++) r[i] = a[5-i];
`endif
        return {10'd0, r};
    endfunction

    task automatic applyStimulus(input logic ed, input logic start, input logic [15:0] di,
                                 input logic hold);
        bus.ED    = ed;
        bus.START = start;
        bus.DI    = di;
        bus.HOLD  = hold;
        @(posedge clk);
        #1;
    endtask

    // Reset is applied with ED/START active to show reset wins.
    task automatic doReset();
        rst       = 1'b1;
        bus.ED    = 1'b1;
        bus.START = 1'b1;
        bus.DI    = 16'h1234;
        bus.HOLD  = 1'b0;
        @(posedge clk);
        #1;
        rst       = 1'b0;
        bus.START = 1'b0;
    endtask

    task automatic checkOutput(input string name, input logic [15:0] exp_do, input logic exp_dv,
                               input logic exp_rdy, input logic exp_ovf);
        checks++;
        if (bus.DO !== exp_do) begin
            errors++;
            $display("[TB] FAIL %s DO: got %0d expected %0d", name, bus.DO, exp_do);
        end
        checks++;
        if (bus.DVALID !== exp_dv) begin
            errors++;
            $display("[TB] FAIL %s DVALID: got %b expected %b", name, bus.DVALID, exp_dv);
        end
        checks++;
        if (bus.RDY !== exp_rdy) begin
            errors++;
            $display("[TB] FAIL %s RDY: got %b expected %b", name, bus.RDY, exp_rdy);
        end
        checks++;
        if (bus.OVF !== exp_ovf) begin
            errors++;
            $display("[TB] FAIL %s OVF: got %b expected %b", name, bus.OVF, exp_ovf);
        end
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        int c;
        int rdy_seen;
        int dv_count;
        logic [15:0] e_do;
        logic e_dv;
        logic e_rdy;
        logic e_ovf;

        bus.ED    = 1'b0;
        bus.START = 1'b0;
        bus.DI    = '0;
        bus.HOLD  = 1'b0;

        // Single frame 0..63: sample 0 appears in cycle 65, last sample in cycle 128.
        for (int i = 0; i < 130; i++) begin
            c = i + 1;
            vecs[i].start = (i == 0);
            vecs[i].di    = (i < 64) ? 16'(i) : 16'hFFFF;
            if (c >= 65 && c <= 128) begin
                vecs[i].exp_do  = ord(c - 65);
                vecs[i].exp_dv  = 1'b1;
                vecs[i].exp_rdy = (c == 65);
            end else begin
                vecs[i].exp_do  = (c > 128) ? ord(63) : 16'd0;
                vecs[i].exp_dv  = 1'b0;
                vecs[i].exp_rdy = 1'b0;
            end
        end

        $display("[TB] single frame");
        doReset();
        checkOutput("reset", 16'd0, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 130; i++) begin
            applyStimulus(1'b1, vecs[i].start, vecs[i].di, 1'b0);
            checkOutput($sformatf("frame c%0d", i + 1), vecs[i].exp_do, vecs[i].exp_dv,
                        vecs[i].exp_rdy, 1'b0);
        end

        $display("[TB] ED toggling");
        doReset();
        rdy_seen = 0;
        for (int i = 0; i < 130; i++) begin
            applyStimulus(1'b1, vecs[i].start, vecs[i].di, 1'b0);
            checkOutput($sformatf("ed on c%0d", i + 1), vecs[i].exp_do, vecs[i].exp_dv,
                        vecs[i].exp_rdy, 1'b0);
            rdy_seen += int'(bus.RDY);
            applyStimulus(1'b0, 1'b1, 16'hBEEF, 1'b1);
            checkOutput($sformatf("ed off c%0d", i + 1), vecs[i].exp_do, vecs[i].exp_dv,
                        vecs[i].exp_rdy, 1'b0);
        end
        checks++;
        if (rdy_seen != 1) begin
            errors++;
            $display("[TB] FAIL ed rdy count: got %0d expected 1", rdy_seen);
        end

        $display("[TB] back-to-back frames");
        doReset();
        dv_count = 0;
        for (int i = 0; i < 195; i++) begin
            c = i + 1;
            applyStimulus(1'b1, (i == 0 || i == 64),
                          (i < 64) ? 16'(i) : ((i < 128) ? 16'(100 + i - 64) : 16'd0), 1'b0);
            e_rdy = 1'b0;
            e_dv  = 1'b1;
            if (c >= 65 && c <= 128) begin
                e_do  = ord(c - 65);
                e_rdy = (c == 65);
            end else if (c >= 129 && c <= 192) begin
                e_do  = 16'd100 + ord(c - 129);
                e_rdy = (c == 129);
            end else begin
                e_do = (c > 192) ? 16'd163 : 16'd0;
                e_dv = 1'b0;
            end
            dv_count += int'(bus.DVALID);
            checkOutput($sformatf("b2b c%0d", c), e_do, e_dv, e_rdy, 1'b0);
        end
        checks++;
        if (dv_count != 128) begin
            errors++;
            $display("[TB] FAIL b2b dvalid count: got %0d expected 128", dv_count);
        end

        $display("[TB] hold and overrun");
        doReset();
        for (int i = 0; i < 194; i++) begin
            c = i + 1;
            applyStimulus(1'b1, (i == 0 || i == 64),
                          (i < 64) ? 16'(i) : ((i < 128) ? 16'(200 + i - 64) : 16'd0),
                          (i >= 70 && i <= 79));
            e_rdy = 1'b0;
            e_dv  = 1'b1;
            e_ovf = (c >= 128);
            if (c < 65) begin
                e_do = 16'd0;
                e_dv = 1'b0;
            end else if (c <= 70) begin
                e_do  = ord(c - 65);
                e_rdy = (c == 65);
            end else if (c <= 80) begin
                e_do = ord(5);
                e_dv = 1'b0;
            end else if (c <= 128) begin
                e_do = ord(c - 75);
            end else if (c <= 192) begin
                e_do  = 16'd200 + ord(c - 129);
                e_rdy = (c == 129);
            end else begin
                e_do = 16'd263;
                e_dv = 1'b0;
            end
            checkOutput($sformatf("ovf c%0d", c), e_do, e_dv, e_rdy, e_ovf);
        end
        doReset();
        checkOutput("ovf cleared by reset", 16'd0, 1'b0, 1'b0, 1'b0);

        $display("[TB] start restart");
        for (int i = 0; i < 150; i++) begin
            c = i + 1;
            applyStimulus(1'b1, (i == 0 || i == 20),
                          (i < 20) ? 16'(500 + i) : ((i < 84) ? 16'(i - 20) : 16'd0), 1'b0);
            if (c >= 85 && c <= 148) begin
                checkOutput($sformatf("restart c%0d", c), ord(c - 85), 1'b1, (c == 85), 1'b0);
            end else begin
                checkOutput($sformatf("restart c%0d", c), (c > 148) ? ord(63) : 16'd0,
                            1'b0, 1'b0, 1'b0);
            end
        end

        $display("[TB] reset mid-frame");
        for (int i = 0; i < 30; i++) begin
            applyStimulus(1'b1, (i == 0), 16'(700 + i), 1'b0);
        end
        doReset();
        checkOutput("mid-frame reset", 16'd0, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 70; i++) begin
            applyStimulus(1'b1, 1'b0, 16'(900 + i), 1'b0);
            checkOutput($sformatf("idle after reset c%0d", i + 1), 16'd0, 1'b0, 1'b0, 1'b0);
        end
        for (int i = 0; i < 66; i++) begin
            c = i + 1;
            applyStimulus(1'b1, (i == 0), (i < 64) ? 16'(300 + i) : 16'd0, 1'b0);
            if (c >= 65) begin
                checkOutput($sformatf("new frame c%0d", c), 16'd300 + ord(c - 65), 1'b1,
                            (c == 65), 1'b0);
            end
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
